// File: rtl/rails_pkg.sv
// Shared definitions for the rail sequencer: FSM state encoding, default
// timing parameters, rail level width and the level-to-rail decode.
package rails_pkg;

  typedef enum logic [2:0] {
    ST_OFF   = 3'd0,
    ST_UP    = 3'd1,
    ST_ON    = 3'd2,
    ST_DOWN  = 3'd3,
    ST_FAULT = 3'd4
  } rail_state_e;

  localparam int STEP_CYCLES_DEF = 100000;
  localparam int TMR_BITS_DEF    = 20;
  localparam int LVL_W           = 2;
  localparam logic [LVL_W-1:0] LVL_MAX = 2'd3;

  // Thermometer decode of the rail level: {lp60v, lp30v, lp15v}.
  function automatic logic [2:0] lvl2rails(input logic [LVL_W-1:0] lvl);
    return {lvl == 2'd3, lvl >= 2'd2, lvl >= 2'd1};
  endfunction

endpackage

// File: rtl/rails_sequencer_sync2.sv
// Two-flop synchronizer for a single asynchronous level.
// Ports: clk, rst_n (async active-low, clears to 0), d_i (async input),
//        q_o (synchronized output, two clk edges of latency).
module sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/rails_sequencer.sv
// Timed power-rail sequencer for the LP15V/LP30V/LP60V rails and their
// active-low output enable. A single enable level walks the rails up
// (15V, 30V, 60V, then OE) and down (OE, 60V, 30V, 15V) with a fixed dwell
// of STEP_CYCLES clocks per step. A fault input shuts everything off at once
// and latches until fault_clr is pulsed with fault and en both low.
// Ports:
//   clk, rst_n            clock, async active-low reset
//   en, fault             async levels, synchronized internally
//   fault_clr             one-cycle clk-synchronous fault clear
//   rails_lp15v/30v/60v   rail enables (active-high)
//   rails_oe_n            rail output enable (active-low)
//   ready, busy, faulted  status flags (ON / UP-or-DOWN / FAULT)
//   state                 current state encoding
// All outputs are registered.
module rails_sequencer
  import rails_pkg::*;
#(
  parameter int STEP_CYCLES = STEP_CYCLES_DEF,
  parameter int TMR_BITS    = TMR_BITS_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       fault,
  input  logic       fault_clr,
  output logic       rails_lp15v,
  output logic       rails_lp30v,
  output logic       rails_lp60v,
  output logic       rails_oe_n,
  output logic       ready,
  output logic       busy,
  output logic       faulted,
  output logic [2:0] state
);

  localparam logic [TMR_BITS-1:0] TMR_LOAD = TMR_BITS'(STEP_CYCLES - 1);

  logic en_s;
  logic fault_s;

  sync2 u_sync_en (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (en),
    .q_o   (en_s)
  );

  sync2 u_sync_fault (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (fault),
    .q_o   (fault_s)
  );

  rail_state_e       state_q, state_d;
  logic [LVL_W-1:0]  lvl_q, lvl_d;
  logic [TMR_BITS-1:0] tmr_q, tmr_d;
  logic              oe_n_q, oe_n_d;
  logic [2:0]        rails_q;
  logic              ready_q, busy_q, faulted_q;
  logic              expired;

  // Timer sits at zero once expired; it never wraps.
  assign expired = (tmr_q == '0);

  always_comb begin
    state_d = state_q;
    lvl_d   = lvl_q;
    oe_n_d  = oe_n_q;
    tmr_d   = expired ? '0 : tmr_q - 1'b1;

    if (fault_s) begin
      state_d = ST_FAULT;
      lvl_d   = '0;
      oe_n_d  = 1'b1;
      tmr_d   = '0;
    end else begin
      unique case (state_q)
        ST_OFF: begin
          if (en_s) begin
            state_d = ST_UP;
            lvl_d   = 2'd1;
            tmr_d   = TMR_LOAD;
          end
        end
        ST_UP: begin
          // Losing en wins over a coincident expiry: no further step up.
          if (!en_s) begin
            state_d = ST_DOWN;
            oe_n_d  = 1'b1;
            tmr_d   = TMR_LOAD;
          end else if (expired) begin
            if (lvl_q != LVL_MAX) begin
              lvl_d = lvl_q + 2'd1;
              tmr_d = TMR_LOAD;
            end else if (oe_n_q) begin
              // All rails up: enable outputs, then one more dwell before ON.
              oe_n_d = 1'b0;
              tmr_d  = TMR_LOAD;
            end else begin
              state_d = ST_ON;
            end
          end
        end
        ST_ON: begin
          if (!en_s) begin
            state_d = ST_DOWN;
            oe_n_d  = 1'b1;
            tmr_d   = TMR_LOAD;
          end
        end
        ST_DOWN: begin
          // en is ignored here; the ramp always completes to OFF.
          if (expired) begin
            lvl_d = lvl_q - 2'd1;
            tmr_d = TMR_LOAD;
            if (lvl_q == 2'd1) state_d = ST_OFF;
          end
        end
        ST_FAULT: begin
          tmr_d = '0;
          if (fault_clr && !en_s) state_d = ST_OFF;
        end
        default: begin
          state_d = ST_OFF;
          lvl_d   = '0;
          oe_n_d  = 1'b1;
          tmr_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_OFF;
      lvl_q     <= '0;
      tmr_q     <= '0;
      oe_n_q    <= 1'b1;
      rails_q   <= '0;
      ready_q   <= 1'b0;
      busy_q    <= 1'b0;
      faulted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      lvl_q     <= lvl_d;
      tmr_q     <= tmr_d;
      oe_n_q    <= oe_n_d;
      rails_q   <= lvl2rails(lvl_d);
      ready_q   <= (state_d == ST_ON);
      busy_q    <= (state_d == ST_UP) || (state_d == ST_DOWN);
      faulted_q <= (state_d == ST_FAULT);
    end
  end

  assign rails_lp15v = rails_q[0];
  assign rails_lp30v = rails_q[1];
  assign rails_lp60v = rails_q[2];
  assign rails_oe_n  = oe_n_q;
  assign ready       = ready_q;
  assign busy        = busy_q;
  assign faulted     = faulted_q;
  assign state       = state_q;

endmodule

// File: tb/tb_rails_sequencer.sv
// Self-checking bench for rails_sequencer with STEP_CYCLES=4. A timing-based
// reference model (edge index of each ramp start plus elapsed-time arithmetic)
// predicts every output on every cycle; scripted scenarios add literal checks
// on step spacing, pin latency and fault handling, followed by random traffic.
module tb_rails_sequencer;

  localparam int STEP = 4;
  localparam int S_L15 = 0, S_L30 = 1, S_L60 = 2, S_OEN = 3, S_RDY = 4,
                 S_FLT = 5, S_DOWN = 6;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b0, fault = 1'b0, fault_clr = 1'b0;
  logic l15, l30, l60, oe_n, ready, busy, faulted;
  logic [2:0] state;

  always #5 clk = ~clk;

  rails_sequencer #(.STEP_CYCLES(STEP), .TMR_BITS(4)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .fault(fault), .fault_clr(fault_clr),
    .rails_lp15v(l15), .rails_lp30v(l30), .rails_lp60v(l60),
    .rails_oe_n(oe_n), .ready(ready), .busy(busy), .faulted(faulted),
    .state(state)
  );

  int cyc_tot = 0, cyc_pass = 0, lit_tot = 0, lit_pass = 0;

  // ---------------- reference model ----------------
  // ms: 0 OFF, 1 UP, 2 ON, 3 DOWN, 4 FAULT. mt0 = edge index where the
  // current ramp started, mbase = level at the start of a down ramp.
  int ms = 0, mlvl = 0, mbase = 0, mt0 = 0, n = 0;
  bit moe = 0, es1 = 0, es2 = 0, fs1 = 0, fs2 = 0;

  task automatic model_step();
    int e;
    e = n - mt0;
    if (fs2) begin
      ms = 4; mlvl = 0; moe = 0;
    end else begin
      case (ms)
        0: if (es2) begin ms = 1; mt0 = n; mlvl = 1; end
        1: if (!es2) begin
             ms = 3; mt0 = n; mbase = mlvl; moe = 0;
           end else begin
             mlvl = (1 + e / STEP > 3) ? 3 : 1 + e / STEP;
             moe  = (e >= 3 * STEP);
             if (e >= 4 * STEP) ms = 2;
           end
        2: if (!es2) begin ms = 3; mt0 = n; mbase = 3; moe = 0; end
        3: begin
             mlvl = mbase - e / STEP;
             if (mlvl == 0) ms = 0;
           end
        4: if (fault_clr && !es2) ms = 0;
        default: ;
      endcase
    end
  endtask

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      ms = 0; mlvl = 0; moe = 0; mbase = 0; mt0 = 0; n = 0;
      es1 = 0; es2 = 0; fs1 = 0; fs2 = 0;
    end else begin
      n++;
      model_step();
      es2 = es1; es1 = en;
      fs2 = fs1; fs1 = fault;
    end
  end

  function automatic logic [9:0] exp_vec();
    return {3'(ms), mlvl == 3, mlvl >= 2, mlvl >= 1, !moe,
            ms == 2, ms == 1 || ms == 3, ms == 4};
  endfunction

  initial forever begin
    @(negedge clk);
    cyc_tot++;
    if ({state, l60, l30, l15, oe_n, ready, busy, faulted} === exp_vec())
      cyc_pass++;
    else
      $display("FAIL cycle %0d: dut=%b expected=%b", n,
               {state, l60, l30, l15, oe_n, ready, busy, faulted}, exp_vec());
  end

  // ---------------- literal checks ----------------
  task automatic chk(input string name, input int act, input int expv);
    lit_tot++;
    if (act == expv) lit_pass++;
    else $display("FAIL %s: got %0d, want %0d", name, act, expv);
  endtask

  function automatic logic sig(input int w);
    case (w)
      S_L15:  return l15;
      S_L30:  return l30;
      S_L60:  return l60;
      S_OEN:  return oe_n;
      S_RDY:  return ready;
      S_FLT:  return faulted;
      S_DOWN: return state == 3'd3;
      default: return 1'b0;
    endcase
  endfunction

  // Count negedges until the selected output reaches val (bounded).
  task automatic wait_for(input int w, input logic val, output int edges);
    edges = 0;
    while (sig(w) !== val && edges < 200) begin
      @(negedge clk);
      edges++;
    end
  endtask

  task automatic clr_pulse();
    fault_clr = 1'b1;
    @(negedge clk);
    fault_clr = 1'b0;
  endtask

  initial begin
    int d;
    repeat (3) @(negedge clk);
    chk("reset_state", state, 0);
    chk("reset_rails", {l60, l30, l15}, 0);
    chk("reset_oe_n", oe_n, 1);
    chk("reset_flags", {ready, busy, faulted}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Power-up ramp
    en = 1'b1;
    wait_for(S_L15, 1'b1, d); chk("en_pin_to_lp15v", d, 3);
    chk("busy_in_ramp", busy, 1);
    wait_for(S_L30, 1'b1, d); chk("lp30v_step", d, STEP);
    wait_for(S_L60, 1'b1, d); chk("lp60v_step", d, STEP);
    wait_for(S_OEN, 1'b0, d); chk("oe_step", d, STEP);
    wait_for(S_RDY, 1'b1, d); chk("ready_step", d, STEP);

    // Power-down from ON
    en = 1'b0;
    wait_for(S_OEN, 1'b1, d); chk("en_pin_to_oe_off", d, 3);
    wait_for(S_L60, 1'b0, d); chk("lp60v_off_step", d, STEP);
    wait_for(S_L30, 1'b0, d); chk("lp30v_off_step", d, STEP);
    wait_for(S_L15, 1'b0, d); chk("lp15v_off_step", d, STEP);
    chk("down_ends_off", state, 0);

    // Abort at lvl=2, re-raise en during DOWN
    en = 1'b1;
    wait_for(S_L30, 1'b1, d);
    en = 1'b0;
    wait_for(S_DOWN, 1'b1, d); chk("abort_latency", d, 3);
    chk("abort_oe_n", oe_n, 1);
    chk("abort_keeps_lvl", {l60, l30, l15}, 3'b011);
    en = 1'b1;
    wait_for(S_L30, 1'b0, d); chk("abort_lp30v_off", d, STEP);
    wait_for(S_L15, 1'b0, d); chk("abort_lp15v_off", d, STEP);
    chk("abort_reaches_off", state, 0);
    @(negedge clk);
    chk("restart_after_off", state, 1);
    wait_for(S_RDY, 1'b1, d); chk("restart_ready", d, 4 * STEP);

    // Fault in ON, clear rules
    fault = 1'b1;
    wait_for(S_FLT, 1'b1, d); chk("fault_latency", d, 3);
    chk("fault_rails_off", {l60, l30, l15, oe_n, ready}, 5'b00010);
    fault = 1'b0;
    repeat (3) @(negedge clk);
    clr_pulse();
    chk("clr_ignored_en_high", state, 4);
    en = 1'b0;
    repeat (3) @(negedge clk);
    clr_pulse();
    chk("clr_to_off", state, 0);

    // Asynchronous reset mid-ramp at lvl=2
    en = 1'b1;
    wait_for(S_L30, 1'b1, d);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_state", state, 0);
    chk("async_rst_outs", {l60, l30, l15, oe_n, ready, busy, faulted}, 7'b0001000);
    en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Fault seen on the same edge as the first timer expiry in UP
    en = 1'b1;
    wait_for(S_L15, 1'b1, d);
    @(negedge clk);
    fault = 1'b1;
    repeat (3) @(negedge clk);
    chk("expiry_fault_state", state, 4);
    chk("expiry_fault_no_step", {l60, l30, l15}, 0);
    fault = 1'b0;
    en = 1'b0;
    repeat (3) @(negedge clk);
    clr_pulse();

    // Random traffic against the model
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 39) == 0) en = ~en;
      if ($urandom_range(0, 399) == 0) fault = 1'b1;
      else if (fault && $urandom_range(0, 3) == 0) fault = 1'b0;
      fault_clr = ($urandom_range(0, 9) == 0);
    end
    fault_clr = 1'b0;
    repeat (5) @(negedge clk);

    $display("%0d/%0d checks passed", cyc_pass + lit_pass, cyc_tot + lit_tot);
    $finish;
  end

endmodule
